led_fade_driver: RTL and testbench



---
 rtl/led_fade_driver_if.sv | 12 +
 rtl/led_fade_driver.sv | 85 ++++++++
 tb/tb_led_fade_driver.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/led_fade_driver_if.sv
// Pattern/brightness inputs and pin drive of the LED fade stage.
interface led_fade_driver_if #(
   parameter int NUM_LED  = 6,
   parameter int PWM_BITS = 8
);
   logic [NUM_LED-1:0]  led_in;
   logic [PWM_BITS-1:0] bright_max;
   logic [NUM_LED-1:0]  led_out;

   modport master (output led_in, output bright_max, input led_out);
   modport slave  (input led_in, input bright_max, output led_out);
endinterface

// File: rtl/led_fade_driver.sv
// PWM dimmer with linear afterglow per LED; LED_FADE_GAMMA_EN selects squared brightness.
// Latency: led_in edge to led_out change is 3 clk_in cycles (input reg, level reg, pin reg).
// No backpressure: accepts a new pattern and bright_max every cycle.
module led_fade_driver #(
   parameter int NUM_LED    = 6,
   parameter int PWM_BITS   = 8,
   parameter int DECAY_DIV  = 105469,
   parameter int DECAY_STEP = 1,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic              clk_in,
   input logic              btn_rst,
   led_fade_driver_if.slave bus
);
   localparam int DCW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [PWM_BITS-1:0] FULL    = '1;
   localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);
   localparam logic [DCW-1:0]      DC_LAST = DCW'(DECAY_DIV - 1);
   localparam logic [NUM_LED-1:0]  POL     = {NUM_LED{ACTIVE_LOW}};

   logic [NUM_LED-1:0]  led_in_q;
   logic [PWM_BITS-1:0] level [NUM_LED];
   logic [PWM_BITS-1:0] eff   [NUM_LED];
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [DCW-1:0]      decay_cnt;
   logic                tick;
   logic [NUM_LED-1:0]  lit;
   logic [NUM_LED-1:0]  led_out_r;
`ifdef LED_FADE_GAMMA_EN
   logic [2*PWM_BITS-1:0] sq;
`endif

   assign tick        = (decay_cnt == DC_LAST);
   assign bus.led_out = led_out_r;

   always_ff @(posedge clk_in or negedge btn_rst) begin
      if (!btn_rst) begin
         led_in_q  <= '0;
         pwm_cnt   <= '0;
         decay_cnt <= '0;
      end else begin
         led_in_q  <= bus.led_in;
         pwm_cnt   <= pwm_cnt + 1'b1;
         decay_cnt <= tick ? '0 : decay_cnt + 1'b1;
      end
   end

   // A lit request wins over a coincident decay tick; decay saturates at zero.
   always_ff @(posedge clk_in or negedge btn_rst) begin
      if (!btn_rst) begin
         for (int i = 0; i < NUM_LED; i++) level[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_LED; i++) begin
            if (led_in_q[i])
               level[i] <= bus.bright_max;
            else if (tick)
               level[i] <= (level[i] > STEP) ? level[i] - STEP : '0;
         end
      end
   end

   always_comb begin
`ifdef LED_FADE_GAMMA_EN
      sq = '0;
`endif
      lit = '0;
      for (int i = 0; i < NUM_LED; i++) begin
`ifdef LED_FADE_GAMMA_EN
         sq     = (2*PWM_BITS)'(level[i]) * (2*PWM_BITS)'(level[i]);
         eff[i] = sq[2*PWM_BITS-1:PWM_BITS];
`else
         eff[i] = level[i];
`endif
         // Max raw level is solid on, closing the one-count gap of the compare.
         lit[i] = (level[i] == FULL) || (pwm_cnt < eff[i]);
      end
   end

   always_ff @(posedge clk_in or negedge btn_rst) begin
      if (!btn_rst)
         led_out_r <= POL;
      else
         led_out_r <= lit ^ POL;
   end
endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboarded random bench for led_fade_driver against a cycle-count reference model.
module tb_led_fade_driver;
   localparam int NL   = 6;
   localparam int PB   = 8;
   localparam int DIV  = 4;
   localparam int STEP = 16;

   typedef struct packed {
      logic [NL-1:0]        out;
      logic [NL-1:0][PB-1:0] lvl;
   } exp_t;

   logic clk_in  = 1'b0;
   logic btn_rst = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   low_cnt [NL];
   exp_t sb_q [$];

   int            m_lvl [NL];
   logic [NL-1:0] m_inq;
   int            m_n;

   led_fade_driver_if #(.NUM_LED(NL), .PWM_BITS(PB)) bus ();

   led_fade_driver #(
      .NUM_LED(NL), .PWM_BITS(PB), .DECAY_DIV(DIV), .DECAY_STEP(STEP), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk_in (clk_in),
      .btn_rst(btn_rst),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_eff(input int lvl);
`ifdef LED_FADE_GAMMA_EN
      return (lvl * lvl) / 256;
`else
      return lvl;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_lvl[i] = 0;
      m_inq = '0;
      m_n   = 0;
   endtask

   // m_n = clock edges since reset release; pwm phase and tick follow from it directly.
   task automatic drive_step(input logic [NL-1:0] li, input logic [PB-1:0] bm);
      exp_t e;
      bit   tk;
      bus.led_in     = li;
      bus.bright_max = bm;
      tk = ((m_n % DIV) == DIV - 1);
      for (int i = 0; i < NL; i++) begin
         bit on;
         on = (m_lvl[i] == 255) || ((m_n % 256) < model_eff(m_lvl[i]));
         e.out[i] = ~on;
      end
      for (int i = 0; i < NL; i++) begin
         if (m_inq[i])  m_lvl[i] = int'(bm);
         else if (tk)   m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
         e.lvl[i] = m_lvl[i][PB-1:0];
      end
      m_inq = li;
      m_n++;
      sb_q.push_back(e);
   endtask

   task automatic cycle(input logic [NL-1:0] li, input logic [PB-1:0] bm);
      @(negedge clk_in);
      drive_step(li, bm);
   endtask

   task automatic drain();
      @(posedge clk_in);
      #2;
   endtask

   task automatic clear_low();
      for (int i = 0; i < NL; i++) low_cnt[i] = 0;
   endtask

   task automatic duty_window(input string name, input int ch, input logic [PB-1:0] bm, input int exp_low);
      logic [NL-1:0] li;
      li = '0;
      li[ch] = 1'b1;
      repeat (8) cycle(li, bm);
      clear_low();
      repeat (1023) cycle(li, bm);
      drain();
      chk(name, low_cnt[ch], exp_low);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("led_out", bus.led_out, e.out);
            for (int i = 0; i < NL; i++) begin
               chk($sformatf("level[%0d]", i), dut.level[i], e.lvl[i]);
               if (!bus.led_out[i]) low_cnt[i]++;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      model_reset();
      clear_low();
      bus.led_in     = '1;
      bus.bright_max = 8'd255;
      repeat (4) @(posedge clk_in);
      #2;
      chk("reset led_out", bus.led_out, 6'b111111);
      for (int i = 0; i < NL; i++) chk($sformatf("reset level[%0d]", i), dut.level[i], 0);

      // Release with only LED0 requested at full brightness.
      @(negedge clk_in);
      btn_rst = 1'b1;
      drive_step(6'b000001, 8'd255);
      repeat (511) cycle(6'b000001, 8'd255);
      drain();
      chk("full on low cycles ch0", low_cnt[0], 510);
      chk("full on ch1 stays off", low_cnt[1], 0);

      duty_window("dim 64 duty ch1", 1, 8'd64,
`ifdef LED_FADE_GAMMA_EN
                  64);
`else
                  256);
`endif
      duty_window("bm 128 duty ch4", 4, 8'd128,
`ifdef LED_FADE_GAMMA_EN
                  256);
`else
                  512);
`endif

      // Fade out of channel 2 from full brightness.
      repeat (4) cycle(6'b000100, 8'd255);
      repeat (100) cycle(6'b000000, 8'd255);
      drain();
      chk("decay floor level[2]", dut.level[2], 0);
      chk("decay floor pin[2]", bus.led_out[2], 1);

      // Relight landing on a decay tick must load bright_max, not decay.
      repeat (6) cycle(6'b001000, 8'd100);
      while ((m_n % DIV) != DIV - 1) cycle(6'b001000, 8'd100);
      cycle(6'b001000, 8'd200);
      drain();
      chk("relight on tick level[3]", dut.level[3], 200);

      for (int k = 0; k < 120; k++) begin
         logic [NL-1:0] li;
         logic [PB-1:0] bm;
         li = NL'($urandom_range(0, 63));
         bm = ($urandom_range(0, 5) == 0) ? 8'd255 : PB'($urandom_range(0, 255));
         repeat ($urandom_range(1, 40)) cycle(li, bm);
      end

      // Asynchronous reset in the middle of a fade.
      repeat (5) cycle(6'b111111, 8'd255);
      repeat (20) cycle(6'b000000, 8'd255);
      @(posedge clk_in);
      #3;
      btn_rst = 1'b0;
      #1;
      chk("midfade reset led_out", bus.led_out, 6'b111111);
      for (int i = 0; i < NL; i++) chk($sformatf("midfade level[%0d]", i), dut.level[i], 0);
      model_reset();
      repeat (2) @(negedge clk_in);
      btn_rst = 1'b1;
      drive_step(6'b101010, 8'd180);
      for (int k = 0; k < 30; k++) begin
         logic [NL-1:0] li;
         li = NL'($urandom_range(0, 63));
         repeat ($urandom_range(1, 30)) cycle(li, PB'($urandom_range(0, 255)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
